// File: rtl/icache_lookup_unit_pkg.sv
// Shared types and constants for the L1 I-cache lookup stage.
// The default configuration follows the L1 associativity defined here.
package icache_lookup_unit_pkg;

   localparam int unsigned ICACHE_L1_ASSOCIATIVITY = 4;
   localparam int unsigned ICACHE_WAY_IDX_W        = $clog2(ICACHE_L1_ASSOCIATIVITY);
   localparam int unsigned ICACHE_PLRU_W           = ICACHE_L1_ASSOCIATIVITY - 1;

   typedef logic [ICACHE_WAY_IDX_W-1:0] icache_way_idx_t;
   typedef logic [ICACHE_PLRU_W-1:0]    icache_plru_t;

endpackage

// File: rtl/icache_lookup_unit_if.sv
// Lookup request/response bus between tag/data arrays, the lookup stage and the control FSM.
interface icache_lookup_unit_if
   import icache_lookup_unit_pkg::*;
#(
   parameter int unsigned N_WAY  = ICACHE_L1_ASSOCIATIVITY,
   parameter int unsigned N_SET  = 64,
   parameter int unsigned TAG_W  = 20,
   parameter int unsigned LINE_W = 128
);
   logic                       req_valid_i;
   logic                       req_ready_o;
   logic [$clog2(N_SET)-1:0]   req_idx_i;
   logic [TAG_W-1:0]           req_tag_i;
   logic [N_WAY*TAG_W-1:0]     tag_vec_i;
   logic [N_WAY-1:0]           valid_vec_i;
   logic [N_WAY*LINE_W-1:0]    data_vec_i;
   logic                       rsp_valid_o;
   logic                       rsp_ready_i;
   logic                       rsp_hit_o;
   logic [$clog2(N_WAY)-1:0]   rsp_way_o;
   logic [LINE_W-1:0]          rsp_line_o;
   logic [$clog2(N_WAY)-1:0]   rsp_victim_o;
   logic                       rsp_multihit_o;

   modport master (
      output req_valid_i, req_idx_i, req_tag_i, tag_vec_i, valid_vec_i, data_vec_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_line_o, rsp_victim_o, rsp_multihit_o
   );

   modport slave (
      input  req_valid_i, req_idx_i, req_tag_i, tag_vec_i, valid_vec_i, data_vec_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_line_o, rsp_victim_o, rsp_multihit_o
   );
endinterface

// File: rtl/icache_lookup_unit_plru_tree.sv
// Combinational tree pseudo-LRU: heap-ordered node bits, 0 points to the lower subtree.
// Produces the post-touch state and the victim way of the incoming state.
module plru_tree #(
   parameter int unsigned N_WAY = 4
) (
   input  logic [N_WAY-2:0]         i_state,
   input  logic [$clog2(N_WAY)-1:0] i_touch_way,
   output logic [N_WAY-2:0]         o_next_state,
   output logic [$clog2(N_WAY)-1:0] o_victim_way
);
   localparam int unsigned LVL = $clog2(N_WAY);

   logic [N_WAY-1:0] w_sel;

   // Node n sits at level L; it is on the touch path when the way's top L bits equal its position.
   for (genvar n = 0; n < N_WAY - 1; n++) begin : g_node
      localparam int unsigned L   = $clog2(n + 2) - 1;
      localparam int unsigned POS = n + 1 - (1 << L);
      logic w_on_path;
      assign w_on_path       = (i_touch_way >> (LVL - L)) == LVL'(POS);
      assign o_next_state[n] = w_on_path ? ~i_touch_way[LVL-1-L] : i_state[n];
   end

   for (genvar k = 0; k < N_WAY; k++) begin : g_way
      logic [LVL-1:0] w_match;
      for (genvar l = 0; l < LVL; l++) begin : g_lvl
         localparam int unsigned NODE = (1 << l) - 1 + (k >> (LVL - l));
         localparam logic        DIR  = ((k >> (LVL - 1 - l)) & 1) != 0;
         assign w_match[l] = (i_state[NODE] == DIR);
      end
      assign w_sel[k] = &w_match;
   end

   always_comb begin
      o_victim_way = '0;
      for (int unsigned k = 0; k < N_WAY; k++) begin
         if (w_sel[k]) o_victim_way = LVL'(k);
      end
   end

endmodule

// File: rtl/icache_lookup_unit.sv
// L1 I-cache lookup stage: tag compare, hit select, multi-hit flag, PLRU victim,
// one registered response slot behind valid/ready, and saturating hit/miss counters.
module icache_lookup_unit
   import icache_lookup_unit_pkg::*;
#(
   parameter int unsigned N_WAY  = ICACHE_L1_ASSOCIATIVITY,
   parameter int unsigned N_SET  = 64,
   parameter int unsigned TAG_W  = 20,
   parameter int unsigned LINE_W = 128,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   icache_lookup_unit_if.slave      lk_if,
   input  logic                     refill_valid_i,
   input  logic [$clog2(N_SET)-1:0] refill_idx_i,
   input  logic [$clog2(N_WAY)-1:0] refill_way_i,
   output logic [CNT_W-1:0]         hit_cnt_o,
   output logic [CNT_W-1:0]         miss_cnt_o
);
   localparam int unsigned WAY_W  = $clog2(N_WAY);
   localparam int unsigned NHIT_W = WAY_W + 1;
   localparam int unsigned PLRU_W = N_WAY - 1;

   logic [PLRU_W-1:0] r_plru [N_SET];
   logic              r_rsp_valid;
   logic              r_rsp_hit;
   logic              r_rsp_multihit;
   logic [WAY_W-1:0]  r_rsp_way;
   logic [WAY_W-1:0]  r_rsp_victim;
   logic [LINE_W-1:0] r_rsp_line;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;

   logic [N_WAY-1:0]  w_hv;
   logic [NHIT_W-1:0] w_nhit;
   logic              w_hit;
   logic              w_multihit;
   logic              w_inv_any;
   logic              w_ready;
   logic              w_acc;
   logic              w_touch_hit;
   logic [WAY_W-1:0]  w_way;
   logic [WAY_W-1:0]  w_inv_way;
   logic [WAY_W-1:0]  w_plru_victim;
   logic [WAY_W-1:0]  w_victim;
   logic [WAY_W-1:0]  w_unused_ref_victim;
   logic [LINE_W-1:0] w_line;
   logic [PLRU_W-1:0] w_plru_rd;
   logic [PLRU_W-1:0] w_hit_next;
   logic [PLRU_W-1:0] w_ref_base;
   logic [PLRU_W-1:0] w_ref_next;

   // Descending scans leave the lowest-index match in the result.
   always_comb begin
      w_hv      = '0;
      w_nhit    = '0;
      w_way     = '0;
      w_inv_any = 1'b0;
      w_inv_way = '0;
      for (int unsigned k = 0; k < N_WAY; k++) begin
         w_hv[k] = lk_if.valid_vec_i[k] && (lk_if.tag_vec_i[k*TAG_W +: TAG_W] == lk_if.req_tag_i);
         w_nhit  = w_nhit + NHIT_W'(w_hv[k]);
      end
      for (int unsigned k = N_WAY; k > 0; k--) begin
         if (w_hv[k-1]) w_way = WAY_W'(k - 1);
         if (!lk_if.valid_vec_i[k-1]) begin
            w_inv_any = 1'b1;
            w_inv_way = WAY_W'(k - 1);
         end
      end
   end

   assign w_hit       = |w_hv;
   assign w_multihit  = w_nhit > NHIT_W'(1);
   assign w_line      = w_hit ? lk_if.data_vec_i[w_way*LINE_W +: LINE_W] : '0;
   assign w_plru_rd   = r_plru[lk_if.req_idx_i];
   assign w_victim    = w_inv_any ? w_inv_way : w_plru_victim;
   assign w_ready     = !rst_i && !flush_i && (!r_rsp_valid || lk_if.rsp_ready_i);
   assign w_acc       = lk_if.req_valid_i && w_ready;
   assign w_touch_hit = w_acc && w_hit;

   // Refill touch chains after the hit touch when both land in the same set.
   assign w_ref_base = (w_touch_hit && (refill_idx_i == lk_if.req_idx_i)) ? w_hit_next
                                                                          : r_plru[refill_idx_i];

   plru_tree #(.N_WAY(N_WAY)) u_plru_hit (
      .i_state      (w_plru_rd),
      .i_touch_way  (w_way),
      .o_next_state (w_hit_next),
      .o_victim_way (w_plru_victim)
   );

   plru_tree #(.N_WAY(N_WAY)) u_plru_refill (
      .i_state      (w_ref_base),
      .i_touch_way  (refill_way_i),
      .o_next_state (w_ref_next),
      .o_victim_way (w_unused_ref_victim)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rsp_valid    <= 1'b0;
         r_rsp_hit      <= 1'b0;
         r_rsp_multihit <= 1'b0;
         r_rsp_way      <= '0;
         r_rsp_victim   <= '0;
         r_rsp_line     <= '0;
         r_hit_cnt      <= '0;
         r_miss_cnt     <= '0;
         for (int unsigned s = 0; s < N_SET; s++) r_plru[s] <= '0;
      end else if (flush_i) begin
         r_rsp_valid <= 1'b0;
         for (int unsigned s = 0; s < N_SET; s++) r_plru[s] <= '0;
      end else begin
         if (w_acc) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_hit      <= w_hit;
            r_rsp_multihit <= w_multihit;
            r_rsp_way      <= w_way;
            r_rsp_victim   <= w_victim;
            r_rsp_line     <= w_line;
            if (w_hit) begin
               if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
               if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
         end else if (lk_if.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
         end
         if (w_touch_hit)    r_plru[lk_if.req_idx_i] <= w_hit_next;
         if (refill_valid_i) r_plru[refill_idx_i]    <= w_ref_next;
      end
   end

   assign lk_if.req_ready_o    = w_ready;
   assign lk_if.rsp_valid_o    = r_rsp_valid;
   assign lk_if.rsp_hit_o      = r_rsp_hit;
   assign lk_if.rsp_way_o      = r_rsp_way;
   assign lk_if.rsp_line_o     = r_rsp_line;
   assign lk_if.rsp_victim_o   = r_rsp_victim;
   assign lk_if.rsp_multihit_o = r_rsp_multihit;
   assign hit_cnt_o            = r_hit_cnt;
   assign miss_cnt_o           = r_miss_cnt;

endmodule

// File: tb/tb_icache_lookup_unit.sv
// Bench for icache_lookup_unit: directed cases with literal expectations, then random
// traffic checked every cycle against a behavioural cache-lookup model.
module tb_icache_lookup_unit;
   import icache_lookup_unit_pkg::*;

   localparam int unsigned NW   = ICACHE_L1_ASSOCIATIVITY;
   localparam int unsigned NS   = 8;
   localparam int unsigned TW   = 8;
   localparam int unsigned LW   = 32;
   localparam int unsigned CW   = 4;
   localparam int unsigned IW   = $clog2(NS);
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          refill_valid;
   logic [IW-1:0] refill_idx;
   icache_way_idx_t refill_way;
   logic [CW-1:0] hit_cnt;
   logic [CW-1:0] miss_cnt;

   always #5 clk = ~clk;

   icache_lookup_unit_if #(.N_WAY(NW), .N_SET(NS), .TAG_W(TW), .LINE_W(LW)) lk ();

   icache_lookup_unit #(.N_WAY(NW), .N_SET(NS), .TAG_W(TW), .LINE_W(LW), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .lk_if          (lk),
      .refill_valid_i (refill_valid),
      .refill_idx_i   (refill_idx),
      .refill_way_i   (refill_way),
      .hit_cnt_o      (hit_cnt),
      .miss_cnt_o     (miss_cnt)
   );

   logic [TW-1:0] t_tag  [NW];
   logic [NW-1:0] t_val;
   logic [LW-1:0] t_data [NW];

   int n_checks = 0;
   int n_errors = 0;

   bit            m_init = 1'b0;
   bit            m_valid, m_hit, m_multi;
   int            m_way, m_victim, m_hcnt, m_mcnt;
   logic [LW-1:0] m_line;
   bit   [NS-1:0] m_b0, m_b1, m_b2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Four-way tree: b0 chooses half {0,1}/{2,3}, b1 within {0,1}, b2 within {2,3}.
   function automatic int plru_victim(input int s);
      if (!m_b0[s]) return m_b1[s] ? 1 : 0;
      return m_b2[s] ? 3 : 2;
   endfunction

   task automatic touch(input int s, input int w);
      m_b0[s] = (w < 2);
      if (w < 2) m_b1[s] = (w == 0);
      else       m_b2[s] = (w == 2);
   endtask

   task automatic model_step();
      bit rdy;
      int nh, first, inv, s;
      if (rst) begin
         m_init = 1'b1; m_valid = 0; m_hit = 0; m_multi = 0; m_way = 0; m_victim = 0;
         m_line = '0; m_hcnt = 0; m_mcnt = 0; m_b0 = '0; m_b1 = '0; m_b2 = '0;
         return;
      end
      if (flush) begin
         m_valid = 0; m_b0 = '0; m_b1 = '0; m_b2 = '0;
         return;
      end
      rdy = !m_valid || lk.rsp_ready_i;
      if (lk.req_valid_i && rdy) begin
         nh = 0; first = -1; inv = -1; s = int'(lk.req_idx_i);
         for (int k = 0; k < NW; k++) begin
            if (t_val[k] && t_tag[k] == lk.req_tag_i) begin
               nh++;
               if (first < 0) first = k;
            end
            if (!t_val[k] && inv < 0) inv = k;
         end
         m_valid  = 1;
         m_hit    = nh > 0;
         m_multi  = nh > 1;
         m_way    = (nh > 0) ? first : 0;
         m_line   = (nh > 0) ? t_data[first] : '0;
         m_victim = (inv >= 0) ? inv : plru_victim(s);
         if (nh > 0) begin
            m_hcnt = (m_hcnt == CMAX) ? m_hcnt : m_hcnt + 1;
            touch(s, first);
         end else begin
            m_mcnt = (m_mcnt == CMAX) ? m_mcnt : m_mcnt + 1;
         end
      end else if (lk.rsp_ready_i) begin
         m_valid = 0;
      end
      if (refill_valid) touch(int'(refill_idx), int'(refill_way));
   endtask

   task automatic compare();
      bit exp_ready;
      exp_ready = !rst && !flush && (!m_valid || lk.rsp_ready_i);
      chk("req_ready", 64'(lk.req_ready_o), 64'(exp_ready));
      chk("rsp_valid", 64'(lk.rsp_valid_o), 64'(m_valid));
      chk("hit_cnt",   64'(hit_cnt),        64'(m_hcnt));
      chk("miss_cnt",  64'(miss_cnt),       64'(m_mcnt));
      if (m_valid) begin
         chk("rsp_hit",      64'(lk.rsp_hit_o),      64'(m_hit));
         chk("rsp_way",      64'(lk.rsp_way_o),      64'(m_way));
         chk("rsp_line",     64'(lk.rsp_line_o),     64'(m_line));
         chk("rsp_victim",   64'(lk.rsp_victim_o),   64'(m_victim));
         chk("rsp_multihit", 64'(lk.rsp_multihit_o), 64'(m_multi));
      end
   endtask

   task automatic cycle();
      for (int k = 0; k < NW; k++) begin
         lk.tag_vec_i[k*TW +: TW]  = t_tag[k];
         lk.data_vec_i[k*LW +: LW] = t_data[k];
      end
      lk.valid_vec_i = t_val;
      @(negedge clk);
      if (m_init) compare();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic lines(input logic [TW-1:0] a, b, c, d, input logic [NW-1:0] v);
      t_tag[0] = a; t_tag[1] = b; t_tag[2] = c; t_tag[3] = d; t_val = v;
      for (int k = 0; k < NW; k++) t_data[k] = $urandom();
   endtask

   task automatic req(input int idx, input logic [TW-1:0] tag);
      lk.req_valid_i = 1'b1;
      lk.req_idx_i   = IW'(idx);
      lk.req_tag_i   = tag;
   endtask

   task automatic idle();
      lk.req_valid_i = 1'b0;
      cycle();
   endtask

   logic [LW-1:0] a_line;

   initial begin
      rst = 1'b1; flush = 1'b0; refill_valid = 1'b0; refill_idx = '0; refill_way = '0;
      lk.req_valid_i = 1'b0; lk.req_idx_i = '0; lk.req_tag_i = '0; lk.rsp_ready_i = 1'b1;
      lines(0, 0, 0, 0, '0);
      cycle();
      cycle();
      chk("reset rsp_valid", 64'(lk.rsp_valid_o), 64'd0);
      chk("reset rsp_hit",   64'(lk.rsp_hit_o),   64'd0);
      chk("reset rsp_way",   64'(lk.rsp_way_o),   64'd0);
      chk("reset rsp_line",  64'(lk.rsp_line_o),  64'd0);
      chk("reset victim",    64'(lk.rsp_victim_o), 64'd0);
      chk("reset multihit",  64'(lk.rsp_multihit_o), 64'd0);
      chk("reset counters",  64'({hit_cnt, miss_cnt}), 64'd0);
      chk("reset ready low", 64'(lk.req_ready_o), 64'd0);
      rst = 1'b0;

      lines(8'h10, 8'h20, 8'h30, 8'h40, 4'hF); req(3, 8'h30); cycle();
      chk("basic hit",  64'(lk.rsp_hit_o),  64'd1);
      chk("basic way",  64'(lk.rsp_way_o),  64'd2);
      chk("basic line", 64'(lk.rsp_line_o), 64'(t_data[2]));
      chk("basic hcnt", 64'(hit_cnt),       64'd1);
      idle();

      lines(8'h10, 8'h55, 8'h30, 8'h55, 4'hF); req(3, 8'h55); cycle();
      chk("multi way",  64'(lk.rsp_way_o),      64'd1);
      chk("multi flag", 64'(lk.rsp_multihit_o), 64'd1);
      idle();

      lines(1, 2, 3, 4, 4'hF);
      req(5, 9); cycle(); chk("plru fresh victim", 64'(lk.rsp_victim_o), 64'd0);
      req(5, 1); cycle(); chk("plru hit0 way",     64'(lk.rsp_way_o),    64'd0);
      req(5, 9); cycle(); chk("plru after w0",     64'(lk.rsp_victim_o), 64'd2);
      req(5, 3); cycle(); chk("plru hit2 way",     64'(lk.rsp_way_o),    64'd2);
      req(5, 9); cycle(); chk("plru after w2",     64'(lk.rsp_victim_o), 64'd1);
      lines(1, 2, 3, 4, 4'b1011);
      req(5, 9); cycle(); chk("invalid victim",    64'(lk.rsp_victim_o), 64'd2);
      idle();

      refill_valid = 1'b1; refill_idx = IW'(6); refill_way = '0; cycle();
      refill_valid = 1'b0; lines(1, 2, 3, 4, 4'hF);
      req(6, 9); cycle(); chk("refill victim", 64'(lk.rsp_victim_o), 64'd2);
      idle();

      lines(1, 2, 3, 4, 4'hF); req(1, 4); cycle();
      a_line = t_data[3];
      lk.rsp_ready_i = 1'b0; req(1, 7);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall ready", 64'(lk.req_ready_o), 64'd0);
         chk("stall line",  64'(lk.rsp_line_o),  64'(a_line));
         chk("stall way",   64'(lk.rsp_way_o),   64'd3);
      end
      lk.rsp_ready_i = 1'b1; cycle();
      chk("stall next miss", 64'(lk.rsp_hit_o), 64'd0);
      idle();
      chk("stall hcnt", 64'(hit_cnt),  64'd5);
      chk("stall mcnt", 64'(miss_cnt), 64'd6);

      lines(1, 2, 3, 4, 4'hF); req(2, 1);
      for (int i = 0; i < 20; i++) cycle();
      chk("saturated hcnt", 64'(hit_cnt), 64'd15);
      lk.rsp_ready_i = 1'b0; flush = 1'b1; cycle();
      flush = 1'b0;
      chk("flush rsp_valid", 64'(lk.rsp_valid_o), 64'd0);
      chk("flush hcnt",      64'(hit_cnt),        64'd15);
      chk("flush mcnt",      64'(miss_cnt),       64'd6);
      lk.rsp_ready_i = 1'b1; req(3, 9); cycle();
      chk("flush plru victim", 64'(lk.rsp_victim_o), 64'd0);
      chk("post flush mcnt",   64'(miss_cnt),        64'd7);
      idle();

      for (int c = 0; c < 3000; c++) begin
         rst            = ($urandom_range(0, 199) == 0);
         flush          = ($urandom_range(0, 49) == 0);
         refill_valid   = ($urandom_range(0, 4) == 0);
         refill_idx     = IW'($urandom_range(0, NS - 1));
         refill_way     = icache_way_idx_t'($urandom_range(0, NW - 1));
         lk.rsp_ready_i = ($urandom_range(0, 3) != 0);
         lk.req_valid_i = ($urandom_range(0, 9) < 7);
         lk.req_idx_i   = IW'($urandom_range(0, NS - 1));
         lk.req_tag_i   = TW'($urandom_range(1, 5));
         for (int k = 0; k < NW; k++) begin
            t_tag[k]  = TW'($urandom_range(1, 5));
            t_data[k] = $urandom();
         end
         t_val = ($urandom_range(0, 1) == 1) ? '1 : NW'($urandom_range(0, 15));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/icache_lookup_unit.md
# icache_lookup_unit

Parametrised, pipelined L1 I-cache lookup stage. Compares the request tag against all ways of the addressed set, selects the hit line, flags multi-hit errors, and returns a replacement victim way from per-set tree pseudo-LRU state. Results are registered behind a valid/ready handshake. The block sits between the I-cache tag/data arrays and the I-cache control FSM, and also exports saturating hit/miss counters.

## Interface
- N_WAY, 4: associativity; power of 2, ≥2
- N_SET, 64: number of sets; power of 2
- TAG_W, 20: tag width
- LINE_W, 128: line width in bits
- CNT_W, 32: width of the performance counters
- clk_i  in  1  clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  drops the pending response and clears all PLRU state
- req_valid_i  in  1  lookup request valid
- req_ready_o  out  1  lookup request accepted when high
- req_idx_i  in  log2(N_SET)  set index
- req_tag_i  in  TAG_W  tag to compare
- tag_vec_i  in  N_WAY*TAG_W  tags read from the set; way k occupies bits [k*TAG_W +: TAG_W]
- valid_vec_i  in  N_WAY  valid bits read from the set
- data_vec_i  in  N_WAY*LINE_W  lines read from the set
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer ready
- rsp_hit_o  out  1  at least one way hit
- rsp_way_o  out  log2(N_WAY)  hit way; 0 on a miss
- rsp_line_o  out  LINE_W  line of the hit way; 0 on a miss
- rsp_victim_o  out  log2(N_WAY)  way to refill on a miss
- rsp_multihit_o  out  1  more than one way hit (error)
- refill_valid_i  in  1  a line was written into refill_idx_i/refill_way_i
- refill_idx_i  in  log2(N_SET)  refill set
- refill_way_i  in  log2(N_WAY)  refill way
- hit_cnt_o  out  CNT_W  accepted hits
- miss_cnt_o  out  CNT_W  accepted misses

## Operation
- Accept: req_valid_i && req_ready_o. req_ready_o = !rsp_valid_o || rsp_ready_i.
- Hit vector: hv[k] = valid_vec_i[k] && (tag k == req_tag_i).
- Hit = |hv. Selected way = lowest-index set bit of hv. Multihit = popcount(hv) > 1.
- Victim selection:
  - If any way is invalid, the victim is the lowest-index invalid way.
  - Otherwise the victim is the way chosen by the tree PLRU of the set, read before this cycle's update.
  - The victim is reported on hits as well.
- Tree PLRU:
  - N_WAY-1 bits per set, heap-ordered; node 0 is the root.
  - Bit value 0 means the victim lies in the left (lower) subtree.
  - Touching way w sets each node on the path to w so that it points away from w.
- PLRU updates:
  - An accepted hit touches the set/way of the hit.
  - refill_valid_i touches refill_idx_i/refill_way_i.
  - If both target the same set in one cycle, apply the hit touch first, then the refill touch; the refill wins on shared nodes.
- Counters: each accepted lookup increments hit_cnt_o or miss_cnt_o. Both saturate at 2^CNT_W-1 and are not affected by flush_i.
- Flush:
  - Next cycle: rsp_valid_o=0 and all PLRU bits are 0.
  - A request presented in the flush cycle is not accepted (req_ready_o is forced low while flush_i=1).
- Response hold: while rsp_valid_o && !rsp_ready_i, all rsp_* outputs stay stable.

## Timing
- Latency: one cycle. A request accepted at edge n produces its response valid after edge n, observable in cycle n+1.
- Throughput: one lookup per cycle when rsp_ready_i is held high.
- The arrays are synchronous reads. tag_vec_i, valid_vec_i and data_vec_i must be valid in the same cycle as req_valid_i; the caller aligns them.
- Reset (rst_i=1, synchronous), on the next edge:
  - rsp_valid_o=0, rsp_hit_o=0, rsp_way_o=0, rsp_line_o=0, rsp_victim_o=0, rsp_multihit_o=0
  - counters=0, all PLRU bits=0
  - req_ready_o is 0 while rst_i=1.
- Reset mid-transaction: the pending response is discarded with no counter update; rst_i has priority over flush_i and refill_valid_i.
- A refill in cycle n affects victim selection for lookups accepted from cycle n+1 onward.

## Structure
- Add to memory_pkg:
  - typedefs icache_way_idx_t and icache_plru_t (N_WAY-1 bits)
  - localparams derived from ICACHE_L1_ASSOCIATIVITY
- The PLRU storage is a flop array (N_SET × (N_WAY-1)), reset to 0.
- Sub-module plru_tree (parameter N_WAY):
  - combinational
  - inputs: state, touch_way; outputs: next_state, victim_way
  - instantiated twice, for the hit touch and the refill touch.
- The priority encoder and popcount stay inline.

## Test plan
- N_WAY=4, set 3, ways 0..3 valid with tags 0x10/0x20/0x30/0x40, req_tag=0x30 → cycle+1: rsp_hit=1, rsp_way=2, rsp_line=data[2], hit_cnt=1.
- Same set, ways 1 and 3 both tag 0x55 and valid, req_tag=0x55 → rsp_hit=1, rsp_way=1, rsp_multihit=1.
- All ways valid, PLRU freshly reset, miss → rsp_victim=0. Then hit way 0 → next miss victim=2. Then hit way 2 → next miss victim=1.
- valid_vec=4'b1011, miss → rsp_victim=2, irrespective of PLRU state.
- rsp_ready_i=0 for 3 cycles with back-to-back requests → req_ready_o=0 while stalled, outputs stable, no request lost or duplicated, counters increment exactly once each.
- Counters preset to 2^CNT_W-1 (CNT_W=4), 2 more hits → hit_cnt stays 15. flush_i during a pending response → rsp_valid_o=0 next cycle, counters unchanged.
